// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-back direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned PROC_ADDR_W     = 30;
  localparam int unsigned MEM_ADDR_W      = 28;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } state_e;

  // Index bits needed to select one of num_blocks lines.
  function automatic int unsigned idx_w(input int unsigned num_blocks);
    return $clog2(num_blocks);
  endfunction

  // Whatever is left of the word address above index and word offset.
  function automatic int unsigned tag_w(input int unsigned num_blocks);
    return PROC_ADDR_W - OFF_W - $clog2(num_blocks);
  endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Core-side and memory-side signals of the data cache, bundled as one bus.
interface dcache_wb_if;
  import dcache_pkg::*;

  logic                   proc_read;
  logic                   proc_write;
  logic [PROC_ADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0]      proc_wdata;
  logic [WORD_W-1:0]      proc_rdata;
  logic                   proc_stall;

  logic                   mem_read;
  logic                   mem_write;
  logic [MEM_ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0]     mem_wdata;
  logic [BLOCK_W-1:0]     mem_rdata;
  logic                   mem_ready;

  // Cache view.
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Environment view (core plus slow memory).
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays: one combinational read port, one write port that
// either updates a single word (marking the line dirty) or refills a full line.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned NumBlocks = 8,
  parameter int unsigned IdxW      = idx_w(NumBlocks),
  parameter int unsigned TagW      = tag_w(NumBlocks)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IdxW-1:0]    rd_idx_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TagW-1:0]    rd_tag_o,
  output logic [BLOCK_W-1:0] rd_line_o,
  input  logic [IdxW-1:0]    wr_idx_i,
  input  logic               wr_word_en_i,
  input  logic [OFF_W-1:0]   wr_off_i,
  input  logic [WORD_W-1:0]  wr_word_i,
  input  logic               wr_line_en_i,
  input  logic [TagW-1:0]    wr_tag_i,
  input  logic [BLOCK_W-1:0] wr_line_i,
  input  logic               clr_dirty_i
);

  logic [NumBlocks-1:0] valid_q;
  logic [NumBlocks-1:0] dirty_q;
  logic [TagW-1:0]      tag_q  [NumBlocks];
  logic [BLOCK_W-1:0]   data_q [NumBlocks];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Line status bits; only these are cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_line_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (wr_word_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[wr_idx_i] <= 1'b0;
    end
  end

  // Tag and data payload; meaningless while the line is invalid, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_line_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end else if (wr_word_en_i) begin
      data_q[wr_idx_i][wr_off_i*WORD_W +: WORD_W] <= wr_word_i;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate, direct-mapped L1 data cache. Hits are served in
// the same cycle; misses stall the core while whole lines move to/from memory.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8
) (
  input logic        clk,
  input logic        proc_reset,
  dcache_wb_if.slave bus
);

  localparam int unsigned IdxW = idx_w(NUM_BLOCKS);
  localparam int unsigned TagW = tag_w(NUM_BLOCKS);

  state_e                  state_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [MEM_ADDR_W-1:0]   mem_addr_q;
  logic [BLOCK_W-1:0]      mem_wdata_q;

  logic [TagW-1:0]         req_tag;
  logic [IdxW-1:0]         req_idx;
  logic [OFF_W-1:0]        req_off;
  logic                    line_valid;
  logic                    line_dirty;
  logic [TagW-1:0]         line_tag;
  logic [BLOCK_W-1:0]      line_data;
  logic                    hit;
  logic                    req;
  logic                    is_idle;
  logic [WORD_W-1:0]       sel_word;
  logic                    wr_word_en;
  logic                    wr_line_en;
  logic                    clr_dirty;

  assign req_tag = bus.proc_addr[PROC_ADDR_W-1 -: TagW];
  assign req_idx = bus.proc_addr[OFF_W +: IdxW];
  assign req_off = bus.proc_addr[OFF_W-1:0];

  dcache_line_store #(
    .NumBlocks (NUM_BLOCKS),
    .IdxW      (IdxW),
    .TagW      (TagW)
  ) u_line_store (
    .clk_i        (clk),
    .rst_i        (proc_reset),
    .rd_idx_i     (req_idx),
    .rd_valid_o   (line_valid),
    .rd_dirty_o   (line_dirty),
    .rd_tag_o     (line_tag),
    .rd_line_o    (line_data),
    .wr_idx_i     (req_idx),
    .wr_word_en_i (wr_word_en),
    .wr_off_i     (req_off),
    .wr_word_i    (bus.proc_wdata),
    .wr_line_en_i (wr_line_en),
    .wr_tag_i     (req_tag),
    .wr_line_i    (bus.mem_rdata),
    .clr_dirty_i  (clr_dirty)
  );

  assign hit     = line_valid & (line_tag == req_tag);
  assign req     = bus.proc_read | bus.proc_write;
  assign is_idle = (state_q == StIdle);

  // Hit path, stall and line-store write controls.
  always_comb begin
    sel_word   = line_data[req_off*WORD_W +: WORD_W];
    // A simultaneous read and write is a write, so it returns no data.
    bus.proc_rdata = (is_idle & bus.proc_read & ~bus.proc_write & hit) ? sel_word : '0;
    bus.proc_stall = ~is_idle | (req & ~hit);
    wr_word_en = is_idle & bus.proc_write & hit & ~proc_reset;
    wr_line_en = (state_q == StAllocate) & bus.mem_ready & ~proc_reset;
    clr_dirty  = (state_q == StWriteback) & bus.mem_ready & ~proc_reset;
  end

  // Miss FSM with registered memory requests; mem_ready only affects the next state.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= StWriteback;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {line_tag, req_idx};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= StAllocate;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_tag, req_idx};
            end
          end
        end
        StWriteback: begin
          if (bus.mem_ready) begin
            state_q     <= StAllocate;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {req_tag, req_idx};
          end
        end
        StAllocate: begin
          if (bus.mem_ready) begin
            state_q    <= StIdle;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
